// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: status codes, icodes, register IDs, bubble values.
package y86_pkg;

  localparam int DW = 64;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RRSP  = 4'h4;

  localparam logic [2:0] BUB_STAT  = SAOK;
  localparam logic [3:0] BUB_ICODE = INOP;
  localparam logic [3:0] BUB_DST   = RNONE;

  typedef enum logic {ST_RUN, ST_HALTED} wb_state_e;

  // Unknown status encodings behave as an invalid instruction.
  function automatic logic [2:0] norm_stat(input logic [2:0] s);
    case (s)
      SAOK, SHLT, SADR, SINS: return s;
      default:                return SINS;
    endcase
  endfunction

endpackage

// File: rtl/y86_regfile.sv
// 15-entry register file: two write ports (M wins on collision), two
// write-through read ports for decode, one unforwarded debug port.
module y86_regfile
  import y86_pkg::*;
#(
  parameter int DW   = y86_pkg::DW,
  parameter int NREG = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_e,
  input  logic [3:0]    dst_e,
  input  logic [DW-1:0] val_e,
  input  logic          we_m,
  input  logic [3:0]    dst_m,
  input  logic [DW-1:0] val_m,
  input  logic [3:0]    src_a,
  input  logic [3:0]    src_b,
  output logic [DW-1:0] rval_a,
  output logic [DW-1:0] rval_b,
  input  logic [3:0]    dbg_sel,
  output logic [DW-1:0] dbg_data
);

  logic [DW-1:0] rf_q [NREG];
  logic [DW-1:0] rf_d [NREG];

  // Next array contents; M port applied last so it wins (popq %rsp).
  always_comb begin
    rf_d = rf_q;
    if (we_e) rf_d[dst_e] = val_e;
    if (we_m) rf_d[dst_m] = val_m;
  end

  // Array storage, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      rf_q <= rf_d;
    end
  end

  // Read port A: value being committed this cycle is visible immediately.
  always_comb begin
    rval_a = '0;
    if (src_a != RNONE) begin
      if (we_m && src_a == dst_m)      rval_a = val_m;
      else if (we_e && src_a == dst_e) rval_a = val_e;
      else                             rval_a = rf_q[src_a];
    end
  end

  // Read port B: same forwarding priority as port A.
  always_comb begin
    rval_b = '0;
    if (src_b != RNONE) begin
      if (we_m && src_b == dst_m)      rval_b = val_m;
      else if (we_e && src_b == dst_e) rval_b = val_e;
      else                             rval_b = rf_q[src_b];
    end
  end

  // Debug port shows only committed state.
  always_comb begin
    dbg_data = '0;
    if (dbg_sel != RNONE) dbg_data = rf_q[dbg_sel];
  end

endmodule

// File: rtl/pipe_writeback.sv
// Y86-64 write-back stage: W pipeline register, register-file commit,
// and the RUN/HALTED processor status machine.
module pipe_writeback
  import y86_pkg::*;
#(
  parameter int DW   = y86_pkg::DW,
  parameter int NREG = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    m_stat,
  input  logic [3:0]    m_icode,
  input  logic [3:0]    m_dstE,
  input  logic [3:0]    m_dstM,
  input  logic [DW-1:0] m_valE,
  input  logic [DW-1:0] m_valM,
  input  logic          w_stall,
  input  logic          w_bubble,
  input  logic [3:0]    srcA,
  input  logic [3:0]    srcB,
  output logic [DW-1:0] rvalA,
  output logic [DW-1:0] rvalB,
  output logic [2:0]    W_stat,
  output logic [3:0]    W_icode,
  output logic [3:0]    W_dstE,
  output logic [3:0]    W_dstM,
  output logic [DW-1:0] W_valE,
  output logic [DW-1:0] W_valM,
  output logic [2:0]    stat,
  output logic          halted,
  input  logic [3:0]    dbg_sel,
  output logic [DW-1:0] dbg_data
);

  logic [2:0]    w_stat_q,  w_stat_d;
  logic [3:0]    w_icode_q, w_icode_d;
  logic [3:0]    w_dste_q,  w_dste_d;
  logic [3:0]    w_dstm_q,  w_dstm_d;
  logic [DW-1:0] w_vale_q,  w_vale_d;
  logic [DW-1:0] w_valm_q,  w_valm_d;

  wb_state_e     state_q, state_d;
  logic [2:0]    code_q,  code_d;

  logic          we_e, we_m;

  assign halted = (state_q == ST_HALTED);

  // W register next value: stall (or stopped machine) beats bubble beats load.
  always_comb begin
    w_stat_d  = w_stat_q;
    w_icode_d = w_icode_q;
    w_dste_d  = w_dste_q;
    w_dstm_d  = w_dstm_q;
    w_vale_d  = w_vale_q;
    w_valm_d  = w_valm_q;
    if (!halted && !w_stall) begin
      if (w_bubble) begin
        w_stat_d  = BUB_STAT;
        w_icode_d = BUB_ICODE;
        w_dste_d  = BUB_DST;
        w_dstm_d  = BUB_DST;
        w_vale_d  = '0;
        w_valm_d  = '0;
      end else begin
        w_stat_d  = m_stat;
        w_icode_d = m_icode;
        w_dste_d  = m_dstE;
        w_dstm_d  = m_dstM;
        w_vale_d  = m_valE;
        w_valm_d  = m_valM;
      end
    end
  end

  // W register and status state; reset leaves a bubble in W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_stat_q  <= BUB_STAT;
      w_icode_q <= BUB_ICODE;
      w_dste_q  <= BUB_DST;
      w_dstm_q  <= BUB_DST;
      w_vale_q  <= '0;
      w_valm_q  <= '0;
      state_q   <= ST_RUN;
      code_q    <= SAOK;
    end else begin
      w_stat_q  <= w_stat_d;
      w_icode_q <= w_icode_d;
      w_dste_q  <= w_dste_d;
      w_dstm_q  <= w_dstm_d;
      w_vale_q  <= w_vale_d;
      w_valm_q  <= w_valm_d;
      state_q   <= state_d;
      code_q    <= code_d;
    end
  end

  // Status FSM: any non-AOK entry in W stops the machine until reset.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    stat    = code_q;
    case (state_q)
      ST_RUN: begin
        stat = norm_stat(w_stat_q);
        if (norm_stat(w_stat_q) != SAOK) begin
          state_d = ST_HALTED;
          code_d  = norm_stat(w_stat_q);
        end
      end
      default: stat = code_q;
    endcase
  end

  // Only healthy instructions retire; the excepting one writes nothing.
  assign we_e = (w_dste_q != RNONE) && (w_stat_q == SAOK) && !halted;
  assign we_m = (w_dstm_q != RNONE) && (w_stat_q == SAOK) && !halted;

  y86_regfile #(.DW(DW), .NREG(NREG)) u_rf (
    .clk      (clk),
    .rst      (rst),
    .we_e     (we_e),
    .dst_e    (w_dste_q),
    .val_e    (w_vale_q),
    .we_m     (we_m),
    .dst_m    (w_dstm_q),
    .val_m    (w_valm_q),
    .src_a    (srcA),
    .src_b    (srcB),
    .rval_a   (rvalA),
    .rval_b   (rvalB),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data)
  );

  assign W_stat  = w_stat_q;
  assign W_icode = w_icode_q;
  assign W_dstE  = w_dste_q;
  assign W_dstM  = w_dstm_q;
  assign W_valE  = w_vale_q;
  assign W_valM  = w_valm_q;

endmodule

// File: tb/tb_pipe_writeback.sv
// Bench for pipe_writeback: directed table, hand sequences for halt/reset,
// and random traffic checked against a retirement-level model.
module tb_pipe_writeback;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  m_stat = 3'd1;
  logic [3:0]  m_icode = 4'h1, m_dstE = 4'hF, m_dstM = 4'hF;
  logic [63:0] m_valE = '0, m_valM = '0;
  logic        w_stall = 1'b0, w_bubble = 1'b0;
  logic [3:0]  srcA = 4'hF, srcB = 4'hF, dbg_sel = 4'h0;
  logic [63:0] rvalA, rvalB, W_valE, W_valM, dbg_data;
  logic [2:0]  W_stat, stat;
  logic [3:0]  W_icode, W_dstE, W_dstM;
  logic        halted;

  int errors = 0;
  int checks = 0;

  pipe_writeback #(.DW(64), .NREG(15)) dut (
    .clk(clk), .rst(rst),
    .m_stat(m_stat), .m_icode(m_icode), .m_dstE(m_dstE), .m_dstM(m_dstM),
    .m_valE(m_valE), .m_valM(m_valM),
    .w_stall(w_stall), .w_bubble(w_bubble),
    .srcA(srcA), .srcB(srcB), .rvalA(rvalA), .rvalB(rvalB),
    .W_stat(W_stat), .W_icode(W_icode), .W_dstE(W_dstE), .W_dstM(W_dstM),
    .W_valE(W_valE), .W_valM(W_valM),
    .stat(stat), .halted(halted),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic edge_settle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    #1;
  endtask

  task automatic drive_m(input logic [2:0] st, input logic [3:0] ic, input logic [3:0] de,
                         input logic [3:0] dm, input logic [63:0] ve, input logic [63:0] vm);
    m_stat = st; m_icode = ic; m_dstE = de; m_dstM = dm; m_valE = ve; m_valM = vm;
  endtask

  // ---------------- reference model (architectural view) ----------------
  typedef struct {
    logic [2:0]  st;
    logic [3:0]  ic, de, dm;
    logic [63:0] ve, vm;
  } winstr_t;

  logic [63:0] mrf [15];
  winstr_t     mw;
  bit          mstop;
  logic [2:0]  mcode;

  function automatic logic [2:0] code_of(input logic [2:0] s);
    return (s >= 3'd1 && s <= 3'd4) ? s : 3'd4;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 15; i++) mrf[i] = '0;
    mw = '{st: 3'd1, ic: 4'h1, de: 4'hF, dm: 4'hF, ve: '0, vm: '0};
    mstop = 0;
    mcode = 3'd1;
  endtask

  // Register value as seen once the instruction sitting in W has retired.
  function automatic logic [63:0] retired_val(input logic [3:0] r);
    logic [63:0] v;
    if (r == 4'hF) return '0;
    v = mrf[r];
    if (!mstop && mw.st == 3'd1) begin
      if (mw.de == r) v = mw.ve;
      if (mw.dm == r) v = mw.vm;
    end
    return v;
  endfunction

  task automatic model_clock();
    bit was_stopped;
    was_stopped = mstop;
    if (!was_stopped) begin
      if (mw.st == 3'd1) begin
        if (mw.de != 4'hF) mrf[mw.de] = mw.ve;
        if (mw.dm != 4'hF) mrf[mw.dm] = mw.vm;
      end else begin
        mstop = 1;
        mcode = code_of(mw.st);
      end
      if (!w_stall) begin
        if (w_bubble) mw = '{st: 3'd1, ic: 4'h1, de: 4'hF, dm: 4'hF, ve: '0, vm: '0};
        else          mw = '{st: m_stat, ic: m_icode, de: m_dstE, dm: m_dstM, ve: m_valE, vm: m_valM};
      end
    end
  endtask

  task automatic model_compare();
    chk("rnd W_stat",  {61'd0, W_stat},  {61'd0, mw.st});
    chk("rnd W_icode", {60'd0, W_icode}, {60'd0, mw.ic});
    chk("rnd W_dstE",  {60'd0, W_dstE},  {60'd0, mw.de});
    chk("rnd W_dstM",  {60'd0, W_dstM},  {60'd0, mw.dm});
    chk("rnd W_valE",  W_valE, mw.ve);
    chk("rnd W_valM",  W_valM, mw.vm);
    chk("rnd stat",    {61'd0, stat}, {61'd0, mstop ? mcode : code_of(mw.st)});
    chk("rnd halted",  {63'd0, halted}, {63'd0, mstop});
    chk("rnd rvalA",   rvalA, retired_val(srcA));
    chk("rnd rvalB",   rvalB, retired_val(srcB));
    chk("rnd dbg",     dbg_data, (dbg_sel == 4'hF) ? 64'd0 : mrf[dbg_sel]);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [2:0]  st;
    logic [3:0]  ic, de, dm;
    logic [63:0] ve, vm;
    logic        stl, bub;
    logic [3:0]  sa, sb, ds;
    logic [3:0]  x_ic, x_de, x_dm;
    logic [63:0] x_ra, x_rb, x_dbg;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int halted_cycles;

    // irmovq, two popq flavours, stall/bubble interactions, then a fresh load.
    tbl[0] = '{3'd1, 4'h3, 4'h3, 4'hF, 64'h1234, 64'h0,   1'b0, 1'b0, 4'h3, 4'hF, 4'h3, 4'h3, 4'h3, 4'hF, 64'h1234, 64'h0,    64'h0};
    tbl[1] = '{3'd1, 4'hB, 4'h4, 4'h4, 64'h108,  64'hABC, 1'b0, 1'b0, 4'h4, 4'h3, 4'h3, 4'hB, 4'h4, 4'h4, 64'hABC,  64'h1234, 64'h1234};
    tbl[2] = '{3'd1, 4'hB, 4'h4, 4'h2, 64'h108,  64'hABC, 1'b0, 1'b0, 4'h4, 4'h2, 4'h4, 4'hB, 4'h4, 4'h2, 64'h108,  64'hABC,  64'hABC};
    tbl[3] = '{3'd1, 4'h3, 4'h5, 4'hF, 64'h77,   64'h0,   1'b1, 1'b0, 4'h4, 4'h2, 4'h4, 4'hB, 4'h4, 4'h2, 64'h108,  64'hABC,  64'h108};
    tbl[4] = '{3'd1, 4'h3, 4'h5, 4'hF, 64'h77,   64'h0,   1'b1, 1'b0, 4'h4, 4'h2, 4'h4, 4'hB, 4'h4, 4'h2, 64'h108,  64'hABC,  64'h108};
    tbl[5] = '{3'd1, 4'h3, 4'h5, 4'hF, 64'h77,   64'h0,   1'b1, 1'b1, 4'h4, 4'h2, 4'h4, 4'hB, 4'h4, 4'h2, 64'h108,  64'hABC,  64'h108};
    tbl[6] = '{3'd1, 4'h3, 4'h5, 4'hF, 64'h77,   64'h0,   1'b0, 1'b1, 4'h5, 4'h4, 4'h2, 4'h1, 4'hF, 4'hF, 64'h0,    64'h108,  64'hABC};
    tbl[7] = '{3'd1, 4'h3, 4'h5, 4'hF, 64'h77,   64'h0,   1'b0, 1'b0, 4'h5, 4'h4, 4'h5, 4'h3, 4'h5, 4'hF, 64'h77,   64'h108,  64'h0};

    #7 rst = 1'b0;   // release between edges
    #1;
    chk("reset stat",   {61'd0, stat}, 64'd1);
    chk("reset halted", {63'd0, halted}, 64'd0);
    chk("reset W_icode",{60'd0, W_icode}, 64'd1);

    for (int i = 0; i < 8; i++) begin
      drive_m(tbl[i].st, tbl[i].ic, tbl[i].de, tbl[i].dm, tbl[i].ve, tbl[i].vm);
      w_stall = tbl[i].stl; w_bubble = tbl[i].bub;
      srcA = tbl[i].sa; srcB = tbl[i].sb; dbg_sel = tbl[i].ds;
      edge_settle();
      chk($sformatf("tbl%0d W_icode", i), {60'd0, W_icode}, {60'd0, tbl[i].x_ic});
      chk($sformatf("tbl%0d W_dstE", i),  {60'd0, W_dstE},  {60'd0, tbl[i].x_de});
      chk($sformatf("tbl%0d W_dstM", i),  {60'd0, W_dstM},  {60'd0, tbl[i].x_dm});
      chk($sformatf("tbl%0d rvalA", i),   rvalA, tbl[i].x_ra);
      chk($sformatf("tbl%0d rvalB", i),   rvalB, tbl[i].x_rb);
      chk($sformatf("tbl%0d dbg", i),     dbg_data, tbl[i].x_dbg);
      chk($sformatf("tbl%0d stat", i),    {61'd0, stat}, 64'd1);
    end
    w_stall = 0; w_bubble = 0;

    // Async reset mid-cycle with a populated register file.
    #2;
    rst = 1'b1;
    #1;
    chk("async W_dstE", {60'd0, W_dstE}, 64'hF);
    chk("async W_dstM", {60'd0, W_dstM}, 64'hF);
    chk("async W_icode",{60'd0, W_icode}, 64'd1);
    chk("async stat",   {61'd0, stat}, 64'd1);
    chk("async halted", {63'd0, halted}, 64'd0);
    for (int r = 0; r < 15; r++) begin
      dbg_sel = r[3:0];
      #1;
      chk($sformatf("async dbg r%0d", r), dbg_data, 64'd0);
    end
    rst = 1'b0;
    srcA = 4'hF;
    #1;
    chk("srcA none", rvalA, 64'd0);

    // Halt: excepting entry must not write; later AOK traffic ignored.
    @(posedge clk); #1;
    drive_m(3'd2, 4'h0, 4'h2, 4'hF, 64'h55, 64'h0);
    edge_settle();
    chk("hlt stat in W", {61'd0, stat}, 64'd2);
    chk("hlt not yet",   {63'd0, halted}, 64'd0);
    drive_m(3'd1, 4'h3, 4'h1, 4'hF, 64'h99, 64'h0);
    edge_settle();
    chk("hlt halted", {63'd0, halted}, 64'd1);
    chk("hlt stat",   {61'd0, stat}, 64'd2);
    edge_settle();
    edge_settle();
    dbg_sel = 4'h2; #1;
    chk("hlt rf2 kept", dbg_data, 64'd0);
    dbg_sel = 4'h1; srcA = 4'h1; #1;
    chk("hlt rf1 kept", dbg_data, 64'd0);
    chk("hlt no fwd",   rvalA, 64'd0);
    chk("hlt sticky",   {61'd0, stat}, 64'd2);
    pulse_rst();
    chk("hlt rst stat",   {61'd0, stat}, 64'd1);
    chk("hlt rst halted", {63'd0, halted}, 64'd0);

    // ADR and an illegal code (6 -> INS).
    drive_m(3'd3, 4'h5, 4'h3, 4'hF, 64'h1, 64'h0);
    edge_settle();
    edge_settle();
    chk("adr stat",   {61'd0, stat}, 64'd3);
    chk("adr halted", {63'd0, halted}, 64'd1);
    pulse_rst();
    drive_m(3'd6, 4'h1, 4'hF, 4'hF, 64'h0, 64'h0);
    edge_settle();
    edge_settle();
    chk("ill stat",   {61'd0, stat}, 64'd4);
    chk("ill halted", {63'd0, halted}, 64'd1);
    pulse_rst();

    // Random traffic against the model.
    model_reset();
    halted_cycles = 0;
    for (int c = 0; c < 600; c++) begin
      logic [2:0] st;
      st = ($urandom_range(0, 49) == 0) ? 3'($urandom_range(0, 7)) : 3'd1;
      drive_m(st, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              {$urandom, $urandom}, {$urandom, $urandom});
      if ($urandom_range(0, 3) == 0) m_dstM = m_dstE;
      w_stall  = ($urandom_range(0, 4) == 0);
      w_bubble = ($urandom_range(0, 4) == 0);
      srcA    = 4'($urandom_range(0, 15));
      srcB    = 4'($urandom_range(0, 15));
      dbg_sel = 4'($urandom_range(0, 15));
      if (mstop) halted_cycles++;
      if (halted_cycles > 4) begin
        pulse_rst();
        model_reset();
        halted_cycles = 0;
      end
      #1;
      model_compare();
      @(posedge clk);
      model_clock();
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
